// File: rtl/data_mem_responder.sv
// Handshaked, multi-cycle data RAM responder for the core's load/store port.
// Requests are answered one at a time, after WAIT_STATES programmable stall cycles.
//
// state  | meaning
// IDLE   | ready for a request; latches it on accept
// WAIT   | counting down wait states before the memory access
// ACCESS | single cycle: error check, store commit or load read
// RESP   | response held until the core takes it
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ram [DEPTH_WORDS];

    logic [1:0]       lane;
    logic [IDX_W-1:0] word_idx;
    logic             funct3_ok;
    logic             misaligned;
    logic             out_of_range;
    logic             req_err;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_ext;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             ram_we;

    assign lane     = addr_q[1:0];
    assign word_idx = addr_q[IDX_W+1:2];

    // Error checks operate on the latched request, so request inputs may change after accept.
    always_comb begin
        funct3_ok    = 1'b0;
        misaligned   = 1'b0;
        out_of_range = ({1'b0, addr_q} >= ADDR_LIMIT);
        if (write_q) begin
            funct3_ok = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
        end else begin
            funct3_ok = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                        (funct3_q == 3'b100) || (funct3_q == 3'b101);
        end
        case (funct3_q[1:0])
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = |addr_q[1:0];
            default: misaligned = 1'b0;
        endcase
        req_err = !funct3_ok || misaligned || out_of_range;
    end

    always_comb begin
        rd_word  = out_of_range ? 32'd0 : ram[word_idx];
        rd_byte  = rd_word[8*lane +: 8];
        rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_ext = 32'd0;
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_ext = rd_word;
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
        ram_we = (state_q == ST_ACCESS) && write_q && !req_err;
    end

    // RAM is never cleared; a reset edge coinciding with ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    ram[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d    = req_write;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                err_d   = req_err;
                rdata_d = (write_q || req_err) ? 32'd0 : load_ext;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            write_q    <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
